// File: rtl/mem_responder.sv
// Memory-side responder: boot-loads a byte stream into a single-port 64-bit word array,
// then serves instruction fetches and data loads/stores with data-over-fetch priority.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ready,
    output logic                  i_rvalid,
    output logic [31:0]           i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [63:0]           d_wdata,
    input  logic [7:0]            d_wstrb,
    output logic                  d_ready,
    output logic                  d_rvalid,
    output logic [63:0]           d_rdata,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_byte,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  load_done
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {LOAD, RUN} state_t;
    state_t state;

    logic            running;
    logic            dInRange, iInRange;
    logic [AW-1:0]   dIdx, iIdx, rdIdx;
    logic            dLoad, dStore, iFetch;
    logic            ldAcc, ldFlush;
    logic [2:0]      byteCnt;
    logic [AW:0]     wordPtr;
    logic [63:0]     asmWord, nextWord;
    logic [7:0]      asmStrb, nextStrb;
    logic            wrEn;
    logic [AW-1:0]   wrIdx;
    logic [63:0]     wrData, rdWord;
    logic [7:0]      wrStrb;
    logic [63:0]     mem [DEPTH_WORDS];
    logic            unusedBits;

    // Handshake: a request is taken at the rising edge where req and ready are both high;
    // ready is a same-cycle function of req, and responses pulse rvalid exactly one cycle later.
    assign running   = (state == RUN);
    assign ld_ready  = ~running;
    assign load_done = running;
    assign d_ready   = running & d_req;
    assign i_ready   = running & i_req & ~d_req;

    assign dInRange = ~|d_addr[ADDR_WIDTH-1:3+AW];
    assign iInRange = ~|i_addr[ADDR_WIDTH-1:3+AW];
    assign dIdx     = d_addr[3+AW-1:3];
    assign iIdx     = i_addr[3+AW-1:3];
    assign unusedBits = ^{i_addr[1:0], d_addr[2:0]};

    assign dLoad  = d_ready & ~d_we;
    assign dStore = d_ready & d_we & dInRange;
    assign iFetch = i_ready;
    assign rdIdx  = dLoad ? dIdx : iIdx;
    assign rdWord = mem[rdIdx];

    assign ldAcc   = ~running & ld_valid;
    assign ldFlush = ldAcc & ((byteCnt == 3'd7) | ld_last);

    always_comb begin
        nextWord = asmWord;
        nextStrb = asmStrb;
        nextWord[{byteCnt, 3'b000} +: 8] = ld_byte;
        nextStrb[byteCnt] = 1'b1;
    end

    // The loader and the store path never overlap: one owns the array before RUN, the other after.
    always_comb begin
        wrEn   = 1'b0;
        wrIdx  = '0;
        wrData = '0;
        wrStrb = '0;
        if (ldFlush && !wordPtr[AW]) begin
            wrEn   = 1'b1;
            wrIdx  = wordPtr[AW-1:0];
            wrData = nextWord;
            wrStrb = nextStrb;
        end else if (dStore) begin
            wrEn   = 1'b1;
            wrIdx  = dIdx;
            wrData = d_wdata;
            wrStrb = d_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int b = 0; b < 8; b++) begin
                if (wrStrb[b]) mem[wrIdx][8*b +: 8] <= wrData[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LOAD;
            byteCnt  <= '0;
            wordPtr  <= '0;
            asmWord  <= '0;
            asmStrb  <= '0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            i_rvalid <= iFetch;
            d_rvalid <= dLoad;
            if (dLoad) d_rdata <= dInRange ? rdWord : 64'd0;
            if (iFetch) begin
                if (!iInRange)      i_rdata <= 32'd0;
                else if (i_addr[2]) i_rdata <= rdWord[63:32];
                else                i_rdata <= rdWord[31:0];
            end
            if (ldAcc) begin
                if (ldFlush) begin
                    byteCnt <= '0;
                    asmWord <= '0;
                    asmStrb <= '0;
                    // Saturate past the end so every later byte is dropped.
                    if (!wordPtr[AW]) wordPtr <= wordPtr + (AW+1)'(1);
                end else begin
                    byteCnt <= byteCnt + 3'd1;
                    asmWord <= nextWord;
                    asmStrb <= nextStrb;
                end
                if (ld_last) state <= RUN;
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: a byte-addressed reference array plus response queues
// predict every ready, rvalid and rdata value cycle by cycle.
module tb_mem_responder;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_ready, i_rvalid;
    logic [63:0] i_addr;
    logic [31:0] i_rdata;
    logic        d_req, d_we, d_ready, d_rvalid;
    logic [63:0] d_addr, d_wdata, d_rdata;
    logic [7:0]  d_wstrb;
    logic        ld_valid, ld_last, ld_ready, load_done;
    logic [7:0]  ld_byte;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready),
        .load_done(load_done)
    );

    int          check_cnt = 0;
    int          err_cnt = 0;
    logic [63:0] model [DEPTH];
    logic [63:0] d_exp_q[$];
    logic [31:0] i_exp_q[$];
    logic [63:0] last_d;
    logic [31:0] last_i;
    int          boot_cnt;
    logic [63:0] boot_word;
    logic [7:0]  boot_strb;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_read(input logic [63:0] a);
        if ((a >> 3) >= 64'(DEPTH)) return 64'd0;
        return model[int'(a >> 3)];
    endfunction

    task automatic ref_store(input logic [63:0] a, input logic [63:0] data, input logic [7:0] strb);
        int idx;
        if ((a >> 3) >= 64'(DEPTH)) return;
        idx = int'(a >> 3);
        for (int b = 0; b < 8; b++)
            if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        #1;
        check("rst_i_ready", i_ready, 0);
        check("rst_d_ready", d_ready, 0);
        check("rst_i_rvalid", i_rvalid, 0);
        check("rst_d_rvalid", d_rvalid, 0);
        repeat (2) @(negedge clk);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_load_done", load_done, 0);
        check("rst_ld_ready", ld_ready, 1);
        rst = 1'b0;
        i_req = 1'b0; d_req = 1'b0;
        boot_cnt = 0; boot_word = '0; boot_strb = '0;
        d_exp_q.delete(); i_exp_q.delete();
        last_d = '0; last_i = '0;
    endtask

    task automatic boot_byte(input logic [7:0] b, input logic last);
        int slot;
        if ($urandom_range(0, 2) == 0) begin
            ld_valid = 1'b0;
            @(negedge clk);
        end
        ld_valid = 1'b1; ld_byte = b; ld_last = last;
        i_req = 1'($urandom_range(0, 1)); d_req = 1'($urandom_range(0, 1)); d_we = 1'b0;
        #1;
        check("ld_ready", ld_ready, 1);
        check("load_done_pre", load_done, 0);
        check("i_ready_load", i_ready, 0);
        check("d_ready_load", d_ready, 0);
        slot = boot_cnt % 8;
        boot_word[8*slot +: 8] = b;
        boot_strb[slot] = 1'b1;
        if (slot == 7 || last) begin
            if (boot_cnt / 8 < DEPTH)
                for (int k = 0; k < 8; k++)
                    if (boot_strb[k]) model[boot_cnt / 8][8*k +: 8] = boot_word[8*k +: 8];
            boot_strb = '0;
        end
        boot_cnt++;
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0; i_req = 1'b0; d_req = 1'b0;
        if (last) begin
            check("load_done", load_done, 1);
            check("ld_ready_after", ld_ready, 0);
        end
    endtask

    // One RUN cycle: drive at a falling edge, check readies, then check responses after the next edge.
    task automatic run_cycle(input logic dreq, input logic dwe, input logic [63:0] daddr,
                             input logic [63:0] wdata, input logic [7:0] wstrb,
                             input logic ireq, input logic [63:0] iaddr, output logic iacc);
        logic        dload;
        logic [63:0] w;
        d_req = dreq; d_we = dwe; d_addr = daddr; d_wdata = wdata; d_wstrb = wstrb;
        i_req = ireq; i_addr = iaddr;
        ld_valid = ($urandom_range(0, 3) == 0); ld_byte = 8'($urandom); ld_last = 1'($urandom_range(0, 1));
        #1;
        check("d_ready", d_ready, dreq);
        check("i_ready", i_ready, ireq && !dreq);
        check("ld_ready_run", ld_ready, 0);
        check("load_done_run", load_done, 1);
        iacc  = ireq && !dreq;
        dload = dreq && !dwe;
        if (dload) d_exp_q.push_back(ref_read(daddr));
        if (dreq && dwe) ref_store(daddr, wdata, wstrb);
        if (iacc) begin
            w = ref_read(iaddr);
            i_exp_q.push_back(((iaddr / 4) % 2 == 1) ? w[63:32] : w[31:0]);
        end
        @(negedge clk);
        check("d_rvalid", d_rvalid, dload);
        if (dload && d_exp_q.size() > 0) begin
            last_d = d_exp_q.pop_front();
            check("d_rdata", d_rdata, last_d);
        end else check("d_rdata_hold", d_rdata, last_d);
        check("i_rvalid", i_rvalid, iacc);
        if (iacc && i_exp_q.size() > 0) begin
            last_i = i_exp_q.pop_front();
            check("i_rdata", i_rdata, last_i);
        end else check("i_rdata_hold", i_rdata, last_i);
    endtask

    task automatic do_load(input logic [63:0] a);
        logic acc;
        run_cycle(1'b1, 1'b0, a, 64'd0, 8'd0, 1'b0, 64'd0, acc);
    endtask

    task automatic do_store(input logic [63:0] a, input logic [63:0] data, input logic [7:0] strb);
        logic acc;
        run_cycle(1'b1, 1'b1, a, data, strb, 1'b0, 64'd0, acc);
    endtask

    task automatic do_fetch(input logic [63:0] a);
        logic acc;
        run_cycle(1'b0, 1'b0, 64'd0, 64'd0, 8'd0, 1'b1, a, acc);
    endtask

    function automatic logic [63:0] rand_addr();
        if ($urandom_range(0, 9) == 0)
            return 64'(DEPTH * 8) + 64'($urandom_range(0, 1 << 20)) + ({63'd0, 1'($urandom_range(0, 1))} << 63);
        return 64'($urandom_range(0, 7) * 8 + $urandom_range(0, 7));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc, pend_i;
        logic [63:0] pend_addr;
        rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
        ld_valid = 0; ld_byte = 0; ld_last = 0;

        // Reset mid-load discards the partial word; a fresh 8-byte load defines word 0.
        do_reset();
        for (int k = 0; k < 5; k++) boot_byte(8'(8'h50 + k), 1'b0);
        do_reset();
        for (int k = 0; k < 8; k++) boot_byte(8'(8'h80 + k), k == 7);
        do_load(64'h0);

        // Boot the 16-byte image and fetch both halves of word 0.
        do_reset();
        for (int k = 0; k < 16; k++) boot_byte(8'(k), k == 15);
        do_fetch(64'h0);
        do_fetch(64'h4);
        do_fetch(64'hB);
        for (int k = 2; k < 8; k++) do_store(64'(k * 8), {$urandom, $urandom}, 8'hFF);

        do_store(64'h8, 64'h1122334455667788, 8'h0F);
        do_load(64'h8);
        do_store(64'h18, 64'hDEADBEEFCAFEF00D, 8'h00);
        do_load(64'h18);

        // Data beats fetch; the stalled fetch goes next cycle.
        run_cycle(1'b1, 1'b0, 64'h0, 64'd0, 8'd0, 1'b1, 64'h8, acc);
        run_cycle(1'b0, 1'b0, 64'h0, 64'd0, 8'd0, 1'b1, 64'h8, acc);
        run_cycle(1'b1, 1'b1, 64'h10, 64'hA5A5A5A5_5A5A5A5A, 8'hF0, 1'b1, 64'h14, acc);
        run_cycle(1'b0, 1'b0, 64'h0, 64'd0, 8'd0, 1'b1, 64'h14, acc);

        // Out-of-range accesses.
        do_load(64'h2000);
        do_store(64'h2000, 64'h0123456789ABCDEF, 8'hFF);
        do_load(64'h0);
        do_fetch(64'h2004);

        pend_i = 1'b0; pend_addr = '0;
        for (int n = 0; n < 400; n++) begin
            if (!pend_i && $urandom_range(0, 1) == 1) begin
                pend_i = 1'b1;
                pend_addr = rand_addr();
            end
            run_cycle(($urandom_range(0, 1) == 1), 1'($urandom_range(0, 1)), rand_addr(),
                      {$urandom, $urandom}, 8'($urandom), pend_i, pend_addr, acc);
            if (acc) pend_i = 1'b0;
        end

        // Partial load over an all-ones word, after an aborted 5-byte load; array survives reset.
        do_store(64'h0, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h0; i_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_clears_rvalid", d_rvalid, 0);
        @(negedge clk);
        do_reset();
        for (int k = 0; k < 5; k++) boot_byte(8'(8'h11 + k), 1'b0);
        do_reset();
        boot_byte(8'hAA, 1'b0);
        boot_byte(8'hBB, 1'b0);
        boot_byte(8'hCC, 1'b1);
        do_load(64'h0);
        check("partial_word_const", last_d, 64'hFFFFFFFFFFCCBBAA);

        run_cycle(1'b0, 1'b0, 64'd0, 64'd0, 8'd0, 1'b0, 64'd0, acc);
        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end
endmodule
